round_sequencer: RTL
====================

Name: round_sequencer

Overview:
Sequences one game round at a time for the cat/dog/chicken game. It latches each player's switch choice on a debounced continue press and resolves the winner. It then requests the scenario draw from the datapath/controller pair, waits for screenDone, and updates both scores. The scores drive the displayHEX instances. It replaces ad-hoc scenario latching in top and owns the round state.

Parameters:
WIN_SCORE, 4'd5, score at which a player wins the game (range 1..15)
DRAW_TIMEOUT, 24'd5_000_000, cycles to wait for screenDone before forcing progress (0 disables the timeout)

Ports:
clk  in  1  50 MHz system clock
resetn  in  1  asynchronous active-low reset
stateReset  in  1  synchronous game restart (level, active-high)
userCont  in  1  continue button, active-high level; rising edge detected internally
choice  in  3  one-hot switch choice: cat=001, dog=010, chicken=100
screenDone  in  1  one-cycle pulse from datapath when the scenario draw completes
scenario  out  4  scenario index 0..8 = 3*p1 + p2 (cat=0, dog=1, chicken=2)
drawReq  out  1  one-cycle pulse requesting draw of scenario
winner1  out  1  one-cycle pulse: player 1 won the round
winner2  out  1  one-cycle pulse: player 2 won the round
player1  out  4  player 1 score
player2  out  4  player 2 score
gameOver  out  1  level, high once either score reaches WIN_SCORE
drawTimeout  out  1  sticky flag, set when a draw timed out
roundState  out  3  current state encoding (debug)

Behaviour:
- Reset (async, resetn=0): state=IDLE; scenario=0; drawReq/winner1/winner2=0; player1=player2=0; gameOver=0; drawTimeout=0; edge register=0.
- stateReset=1 (sync): same values as async reset, except the edge register still samples userCont. Takes priority over every transition, including mid-draw. A later screenDone is ignored because the state is no longer WAIT_DRAW.
- Edge detect: contEdge = userCont & ~userCont_q. A held button produces exactly one edge.
- Choice decode: 001→0, 010→1, 100→2. Any other value (zero or multi-hot) decodes to cat (0).
- States and transitions:
  - IDLE: on contEdge → P1_SEL.
  - P1_SEL: on contEdge, latch decoded choice into c1 → P2_SEL.
  - P2_SEL: on contEdge, latch c2; scenario <= 3*c1 + c2 → REQ.
  - REQ: drawReq=1 for exactly one cycle; clear timeout counter → WAIT_DRAW.
  - WAIT_DRAW: on screenDone → SCORE. If DRAW_TIMEOUT≠0 and the counter reaches DRAW_TIMEOUT-1, set drawTimeout → SCORE. If screenDone and timeout coincide, screenDone wins and drawTimeout is not set.
  - SCORE: resolve the round (single cycle) → CHECK.
    - Dog beats cat; cat beats chicken; chicken beats dog; equal choices tie.
    - P1 wins: player1+1, winner1 pulse.
    - P2 wins: player2+1, winner2 pulse.
    - Tie: no change, no pulse.
    - Scores saturate at 15.
  - CHECK: if player1>=WIN_SCORE or player2>=WIN_SCORE → GAME_OVER and gameOver=1; else → P1_SEL.
  - GAME_OVER: scores hold. contEdge clears scores and gameOver → P1_SEL. Only resetn or stateReset also leave this state.
- contEdge outside IDLE/P1_SEL/P2_SEL/GAME_OVER is ignored; it is not queued.
- screenDone outside WAIT_DRAW is ignored.
- scenario holds its value from P2_SEL until the next P2_SEL latch.
- Latency: from the P2 contEdge cycle, drawReq is asserted 2 cycles later. From the screenDone cycle, winner pulse and score update appear 1 cycle later.
- Unused state encodings → IDLE.

Decomposition:
- Shared package game_pkg holds:
  - choice constants CAT=3'b001, DOG=3'b010, CHICKEN=3'b100
  - decoded index constants 0/1/2
  - state encodings IDLE=0, P1_SEL=1, P2_SEL=2, REQ=3, WAIT_DRAW=4, SCORE=5, CHECK=6, GAME_OVER=7
- One sub-module, round_judge: purely combinational. Inputs c1, c2. Outputs p1Win and p2Win. It is reused by any future AI-opponent block.

Test Plan:
- resetn low mid-WAIT_DRAW with scores 3/2 → all outputs 0 immediately; state IDLE; a subsequent screenDone has no effect.
- Edges with choice=010 then 001; screenDone 10 cycles after drawReq → scenario=3; single drawReq pulse; winner1 pulse; player1=1, player2=0.
- choice 100 then 100 → scenario=8; no winner pulse; scores unchanged.
- choice=011 for P1, 001 for P2 → decoded cat/cat; scenario=0; tie.
- Hold userCont high 1000 cycles in P1_SEL → exactly one advance to P2_SEL.
- WIN_SCORE=2, P2 wins two rounds → player2=2, gameOver=1 in GAME_OVER; next contEdge → scores 0, gameOver=0.
- DRAW_TIMEOUT=16, screenDone withheld → SCORE entered 16 cycles after REQ; drawTimeout=1; scoring still applied.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the cat/dog/chicken game:
// choice codes, decoded indices, round states and helper functions.
package game_pkg;

    localparam logic [2:0] CAT     = 3'b001;
    localparam logic [2:0] DOG     = 3'b010;
    localparam logic [2:0] CHICKEN = 3'b100;

    localparam logic [1:0] IDX_CAT     = 2'd0;
    localparam logic [1:0] IDX_DOG     = 2'd1;
    localparam logic [1:0] IDX_CHICKEN = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P1_SEL    = 3'd1,
        P2_SEL    = 3'd2,
        REQ       = 3'd3,
        WAIT_DRAW = 3'd4,
        SCORE     = 3'd5,
        CHECK     = 3'd6,
        GAME_OVER = 3'd7
    } state_t;

    // Zero or multi-hot switch settings fall back to cat.
    function automatic logic [1:0] decode_choice(input logic [2:0] ch);
        logic [1:0] idx;
        case (ch)
            CAT:     idx = IDX_CAT;
            DOG:     idx = IDX_DOG;
            CHICKEN: idx = IDX_CHICKEN;
            default: idx = IDX_CAT;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] scenario_of(input logic [1:0] c1,
                                               input logic [1:0] c2);
        return ({2'b00, c1} * 4'd3) + {2'b00, c2};
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake and status bundle between the game top and round_sequencer.
// master drives the player inputs, slave is the sequencer.
interface round_sequencer_if;

    logic       stateReset;
    logic       userCont;
    logic [2:0] choice;
    logic       screenDone;
    logic [3:0] scenario;
    logic       drawReq;
    logic       winner1;
    logic       winner2;
    logic [3:0] player1;
    logic [3:0] player2;
    logic       gameOver;
    logic       drawTimeout;
    logic [2:0] roundState;

    modport master (
        output stateReset, userCont, choice, screenDone,
        input  scenario, drawReq, winner1, winner2,
        input  player1, player2, gameOver, drawTimeout, roundState
    );

    modport slave (
        input  stateReset, userCont, choice, screenDone,
        output scenario, drawReq, winner1, winner2,
        output player1, player2, gameOver, drawTimeout, roundState
    );

endinterface

// File: rtl/round_judge.sv
// Combinational round resolver: dog beats cat, cat beats chicken,
// chicken beats dog, equal picks tie.
module round_judge
    import game_pkg::*;
(
    input  logic [1:0] c1,
    input  logic [1:0] c2,
    output logic       p1Win,
    output logic       p2Win
);

    // Each side wins only on one of the three beating pairs.
    always_comb begin
        p1Win = (c1 == IDX_DOG     && c2 == IDX_CAT)
             || (c1 == IDX_CAT     && c2 == IDX_CHICKEN)
             || (c1 == IDX_CHICKEN && c2 == IDX_DOG);
        p2Win = (c2 == IDX_DOG     && c1 == IDX_CAT)
             || (c2 == IDX_CAT     && c1 == IDX_CHICKEN)
             || (c2 == IDX_CHICKEN && c1 == IDX_DOG);
    end

endmodule

// File: rtl/round_sequencer.sv
// Round state machine: latches both choices, requests the scenario draw,
// waits for screenDone (or a timeout) and keeps both scores.
module round_sequencer
    import game_pkg::*;
#(
    parameter logic [3:0]  WIN_SCORE    = 4'd5,
    parameter logic [23:0] DRAW_TIMEOUT = 24'd5_000_000
) (
    input  logic               clk,
    input  logic               resetn,
    round_sequencer_if.slave   bus
);

    state_t      state_q, state_d;
    logic        cont_q, cont_d;
    logic [1:0]  c1_q, c1_d;
    logic [1:0]  c2_q, c2_d;
    logic [3:0]  scenario_q, scenario_d;
    logic        draw_req_q, draw_req_d;
    logic        win1_q, win1_d;
    logic        win2_q, win2_d;
    logic [3:0]  p1_q, p1_d;
    logic [3:0]  p2_q, p2_d;
    logic        game_over_q, game_over_d;
    logic        timeout_q, timeout_d;
    logic [23:0] cnt_q, cnt_d;

    logic        cont_edge;
    logic        to_hit;
    logic        resolve;
    logic [1:0]  ch_idx;
    logic        p1_win;
    logic        p2_win;

    assign cont_edge = bus.userCont & ~cont_q;
    assign ch_idx    = decode_choice(bus.choice);
    assign to_hit    = (DRAW_TIMEOUT != 24'd0)
                    && (cnt_q == DRAW_TIMEOUT - 24'd1);

    round_judge u_judge (
        .c1    (c1_q),
        .c2    (c2_q),
        .p1Win (p1_win),
        .p2Win (p2_win)
    );

    // Next-state and output computation; the round result is registered
    // on the way out of WAIT_DRAW so it is visible while in SCORE.
    always_comb begin
        state_d     = state_q;
        cont_d      = bus.userCont;
        c1_d        = c1_q;
        c2_d        = c2_q;
        scenario_d  = scenario_q;
        draw_req_d  = 1'b0;
        win1_d      = 1'b0;
        win2_d      = 1'b0;
        p1_d        = p1_q;
        p2_d        = p2_q;
        game_over_d = game_over_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        resolve     = 1'b0;

        if (bus.stateReset) begin
            state_d     = IDLE;
            c1_d        = 2'd0;
            c2_d        = 2'd0;
            scenario_d  = 4'd0;
            p1_d        = 4'd0;
            p2_d        = 4'd0;
            game_over_d = 1'b0;
            timeout_d   = 1'b0;
            cnt_d       = 24'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cont_edge) state_d = P1_SEL;
                end
                P1_SEL: begin
                    if (cont_edge) begin
                        c1_d    = ch_idx;
                        state_d = P2_SEL;
                    end
                end
                P2_SEL: begin
                    if (cont_edge) begin
                        c2_d       = ch_idx;
                        scenario_d = scenario_of(c1_q, ch_idx);
                        state_d    = REQ;
                    end
                end
                REQ: begin
                    draw_req_d = 1'b1;
                    cnt_d      = 24'd0;
                    state_d    = WAIT_DRAW;
                end
                WAIT_DRAW: begin
                    if (bus.screenDone) begin
                        resolve = 1'b1;
                    end else if (to_hit) begin
                        timeout_d = 1'b1;
                        resolve   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                    if (resolve) begin
                        state_d = SCORE;
                        if (p1_win) begin
                            p1_d   = sat_inc(p1_q);
                            win1_d = 1'b1;
                        end
                        if (p2_win) begin
                            p2_d   = sat_inc(p2_q);
                            win2_d = 1'b1;
                        end
                    end
                end
                SCORE: begin
                    state_d = CHECK;
                end
                CHECK: begin
                    if (p1_q >= WIN_SCORE || p2_q >= WIN_SCORE) begin
                        game_over_d = 1'b1;
                        state_d     = GAME_OVER;
                    end else begin
                        state_d = P1_SEL;
                    end
                end
                GAME_OVER: begin
                    if (cont_edge) begin
                        p1_d        = 4'd0;
                        p2_d        = 4'd0;
                        game_over_d = 1'b0;
                        state_d     = P1_SEL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // All round state and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cont_q      <= 1'b0;
            c1_q        <= 2'd0;
            c2_q        <= 2'd0;
            scenario_q  <= 4'd0;
            draw_req_q  <= 1'b0;
            win1_q      <= 1'b0;
            win2_q      <= 1'b0;
            p1_q        <= 4'd0;
            p2_q        <= 4'd0;
            game_over_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= 24'd0;
        end else begin
            state_q     <= state_d;
            cont_q      <= cont_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            scenario_q  <= scenario_d;
            draw_req_q  <= draw_req_d;
            win1_q      <= win1_d;
            win2_q      <= win2_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            game_over_q <= game_over_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.scenario    = scenario_q;
    assign bus.drawReq     = draw_req_q;
    assign bus.winner1     = win1_q;
    assign bus.winner2     = win2_q;
    assign bus.player1     = p1_q;
    assign bus.player2     = p2_q;
    assign bus.gameOver    = game_over_q;
    assign bus.drawTimeout = timeout_q;
    assign bus.roundState  = state_q;

endmodule
